// File: rtl/ram_arb_pkg.sv
// Shared defaults and helpers for the round-robin RAM port arbiter.
package ram_arb_pkg;

    localparam int unsigned N_REQ_DEF      = 4;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 5;

    // Index width for n items; never returns less than 1 so ports stay legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return (r == 0) ? 32'd1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        logic found;
        int unsigned j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = (32'(ptr) + k) % N_REQ;
            if (!found && req[IDX_W'(j)]) begin
                gnt[IDX_W'(j)] = 1'b1;
                idx            = IDX_W'(j);
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one registered-read RAM port among N_REQ requesters with round-robin
// grant, a registered command stage and an ID-tagged read-return stage.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = N_REQ_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0]              we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]              gnt,
    output logic                          ram_wren,
    output logic                          ram_rden,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout,
    output logic [N_REQ-1:0]              rvalid,
    output logic [DATA_WIDTH-1:0]         rdata
);

    localparam int unsigned IDX_W = clog2(N_REQ);

    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      cmd_id;
    logic                  accept_c;
    logic                  sel_we_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_wdata_c;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign accept_c = |gnt;

    // One-hot mux of the winning requester's command fields.
    always_comb begin
        sel_we_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (gnt[i]) begin
                sel_we_c    = we[i];
                sel_addr_c  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata_c = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept_c) begin
            ptr <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    // Command stage: drives the RAM port the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wren <= 1'b0;
            ram_rden <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            cmd_id   <= '0;
        end else if (accept_c) begin
            ram_wren <= sel_we_c;
            ram_rden <= ~sel_we_c;
            ram_addr <= sel_addr_c;
            ram_din  <= sel_we_c ? sel_wdata_c : '0;
            cmd_id   <= win_idx;
        end else begin
            ram_wren <= 1'b0;
            ram_rden <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            cmd_id   <= '0;
        end
    end

    // Read return lines up with the RAM's one-cycle registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= '0;
        end else begin
            rvalid <= ram_rden ? (N_REQ'(1) << cmd_id) : '0;
        end
    end

    assign rdata = (|rvalid) ? ram_dout : '0;

endmodule
